// File: rtl/adder_substractor_serial_if.sv
// Handshake/data bundle for the digit-serial adder/subtractor.
// Defining ADDSUB_SERIAL_OVF_EN adds the o_Ovf signed-overflow flag.
interface adder_substractor_serial_if #(
  parameter int unsigned WIDTH = 16
);
  logic             i_start;
  logic [WIDTH-1:0] i_A;
  logic [WIDTH-1:0] i_B;
  logic             i_Mode;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_Sum;
  logic             o_Cout;
`ifdef ADDSUB_SERIAL_OVF_EN
  logic             o_Ovf;

  modport master (
    output i_start, i_A, i_B, i_Mode,
    input  o_busy, o_done, o_Sum, o_Cout, o_Ovf
  );
  modport slave (
    input  i_start, i_A, i_B, i_Mode,
    output o_busy, o_done, o_Sum, o_Cout, o_Ovf
  );
`else
  modport master (
    output i_start, i_A, i_B, i_Mode,
    input  o_busy, o_done, o_Sum, o_Cout
  );
  modport slave (
    input  i_start, i_A, i_B, i_Mode,
    output o_busy, o_done, o_Sum, o_Cout
  );
`endif
endinterface

// File: rtl/adder_substractor_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, WIDTH/DIGIT cycles per operation.
// Defining ADDSUB_SERIAL_OVF_EN adds signed-overflow detection on o_Ovf.
module adder_substractor_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input logic                       i_clk,
  input logic                       i_reset,
  adder_substractor_serial_if.slave bus
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] acc_next;
`ifdef ADDSUB_SERIAL_OVF_EN
  logic             ovf_q, ovf_d;
  logic             msb_cin;
`endif

  assign digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};
  // Result fills from the MSB side so the last digit lands in the top bits.
  assign acc_next  = (acc_q >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
`ifdef ADDSUB_SERIAL_OVF_EN
  assign msb_cin   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ digit_sum[DIGIT-1];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef ADDSUB_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.i_start) begin
          state_d = StRun;
          a_d     = bus.i_A;
          // Subtraction as A + ~B + 1: invert B and seed the carry.
          b_d     = bus.i_B ^ {WIDTH{bus.i_Mode}};
          carry_d = bus.i_Mode;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_next;
        carry_d = digit_sum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          sum_d   = acc_next;
          cout_d  = digit_sum[DIGIT];
`ifdef ADDSUB_SERIAL_OVF_EN
          ovf_d   = msb_cin ^ digit_sum[DIGIT];
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef ADDSUB_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef ADDSUB_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.o_busy = (state_q == StRun);
  assign bus.o_done = (state_q == StDone);
  assign bus.o_Sum  = sum_q;
  assign bus.o_Cout = cout_q;
`ifdef ADDSUB_SERIAL_OVF_EN
  assign bus.o_Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_adder_substractor_serial.sv
// Scoreboard bench: a 16/4 instance and a 4/4 (single-digit) instance share one clock and reset.
module tb_adder_substractor_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_substractor_serial_if #(.WIDTH(16)) bw ();
  adder_substractor_serial_if #(.WIDTH(4))  bn ();

  adder_substractor_serial #(.WIDTH(16), .DIGIT(4)) u_wide (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bw)
  );

  adder_substractor_serial #(.WIDTH(4), .DIGIT(4)) u_narrow (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bn)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          done_cyc;
  } exp_t;

  exp_t q_w[$];
  exp_t q_n[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [31:0] got,
                              input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    end
  endfunction

  // Monitor: pops one expectation per o_done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (bw.o_done === 1'b1) begin
      if (q_w.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wide_spurious_done: got o_done=1 required no pulse");
      end else begin
        e = q_w.pop_front();
        chk("wide_sum", 32'(bw.o_Sum), 32'(e.sum));
        chk("wide_cout", 32'(bw.o_Cout), 32'(e.cout));
        chk("wide_latency", 32'(cyc), 32'(e.done_cyc));
`ifdef ADDSUB_SERIAL_OVF_EN
        chk("wide_ovf", 32'(bw.o_Ovf), 32'(e.ovf));
`endif
      end
    end
    if (bn.o_done === 1'b1) begin
      if (q_n.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL narrow_spurious_done: got o_done=1 required no pulse");
      end else begin
        e = q_n.pop_front();
        chk("narrow_sum", 32'(bn.o_Sum), 32'(e.sum));
        chk("narrow_cout", 32'(bn.o_Cout), 32'(e.cout));
        chk("narrow_latency", 32'(cyc), 32'(e.done_cyc));
`ifdef ADDSUB_SERIAL_OVF_EN
        chk("narrow_ovf", 32'(bn.o_Ovf), 32'(e.ovf));
`endif
      end
    end
  end

  // Drive a request, let one edge accept it, then drop i_start.
  task automatic issue(input bit narrow, input logic [15:0] a, input logic [15:0] b,
                       input logic mode, input logic [15:0] es, input logic ec,
                       input logic eo, input bit push);
    exp_t e;
    if (!narrow) begin
      bw.i_A = a; bw.i_B = b; bw.i_Mode = mode; bw.i_start = 1'b1;
    end else begin
      bn.i_A = a[3:0]; bn.i_B = b[3:0]; bn.i_Mode = mode; bn.i_start = 1'b1;
    end
    @(posedge clk);
    #1;
    bw.i_start = 1'b0;
    bn.i_start = 1'b0;
    e.sum      = es;
    e.cout     = ec;
    e.ovf      = eo;
    e.done_cyc = cyc + (narrow ? 1 : 4);
    if (push) begin
      if (narrow) q_n.push_back(e);
      else        q_w.push_back(e);
    end
    if (narrow) chk("narrow_busy_after_accept", 32'(bn.o_busy), 32'd1);
    else        chk("wide_busy_after_accept", 32'(bw.o_busy), 32'd1);
  endtask

  task automatic wait_done(input bit narrow);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = narrow ? (bn.o_done === 1'b1) : (bw.o_done === 1'b1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: got no o_done in 40 cycles required pulse",
               narrow ? "narrow" : "wide");
    end
  endtask

  task automatic run(input bit narrow, input logic [15:0] a, input logic [15:0] b,
                     input logic mode, input logic [15:0] es, input logic ec,
                     input logic eo);
    issue(narrow, a, b, mode, es, ec, eo, 1'b1);
    wait_done(narrow);
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, 32'(bw.o_busy), 32'd0);
    chk({tag, "_done"}, 32'(bw.o_done), 32'd0);
    chk({tag, "_sum"},  32'(bw.o_Sum),  32'd0);
    chk({tag, "_cout"}, 32'(bw.o_Cout), 32'd0);
`ifdef ADDSUB_SERIAL_OVF_EN
    chk({tag, "_ovf"},  32'(bw.o_Ovf),  32'd0);
`endif
  endtask

  initial begin
    bw.i_start = 1'b0; bw.i_A = '0; bw.i_B = '0; bw.i_Mode = 1'b0;
    bn.i_start = 1'b0; bn.i_A = '0; bn.i_B = '0; bn.i_Mode = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    chk("reset_narrow_sum", 32'(bn.o_Sum), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, WIDTH=16 DIGIT=4.
    run(1'b0, 16'd10,    16'd8,     1'b0, 16'd18,    1'b0, 1'b0);
    run(1'b0, 16'd10,    16'd9,     1'b1, 16'd1,     1'b1, 1'b0);
    run(1'b0, 16'd0,     16'd1,     1'b1, 16'hFFFF,  1'b0, 1'b0);
    run(1'b0, 16'hFFFF,  16'h0001,  1'b0, 16'h0000,  1'b1, 1'b0);
    run(1'b0, 16'h7FFF,  16'h0001,  1'b0, 16'h8000,  1'b0, 1'b1);
    run(1'b0, 16'h8000,  16'h0001,  1'b1, 16'h7FFF,  1'b1, 1'b1);
    run(1'b0, 16'h1234,  16'h4321,  1'b0, 16'h5555,  1'b0, 1'b0);

    // Request during RUN must be ignored; then a back-to-back start in the DONE cycle.
    issue(1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
    bw.i_A = 16'hFFFF; bw.i_B = 16'hFFFF; bw.i_Mode = 1'b1; bw.i_start = 1'b1;
    repeat (2) @(negedge clk);
    bw.i_start = 1'b0;
    wait_done(1'b0);
    issue(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
    wait_done(1'b0);
    @(negedge clk);

    // Reset during the second RUN cycle discards the operation.
    issue(1'b0, 16'd5, 16'd3, 1'b0, 16'd8, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_cleared("midrun_reset");
    repeat (8) @(negedge clk);
    chk("midrun_reset_stays_idle", 32'(bw.o_busy), 32'd0);
    run(1'b0, 16'd3, 16'd5, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Single-digit instance: WIDTH=4 DIGIT=4.
    run(1'b1, 16'd10,  16'd9,  1'b1, 16'd1,  1'b1, 1'b0);
    run(1'b1, 16'd7,   16'd1,  1'b0, 16'd8,  1'b0, 1'b1);
    run(1'b1, 16'hF,   16'hF,  1'b0, 16'hE,  1'b1, 1'b0);

    repeat (4) @(negedge clk);
    chk("wide_queue_empty",   32'(q_w.size()), 32'd0);
    chk("narrow_queue_empty", 32'(q_n.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_substractor_serial.md
ADDER_SUBSTRACTOR_SERIAL -- requirements
Module: adder_substractor_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per clock; WIDTH SHALL be a nonzero multiple of DIGIT; N = WIDTH/DIGIT.
REQ-003 SHALL have one clock and a synchronous, active-high reset: i_clk  in  1  rising-edge clock.
REQ-004 i_reset  in  1  synchronous active-high reset.
REQ-005 i_start  in  1  request; accepted only when o_busy=0.
REQ-006 i_A  in  WIDTH  operand A, sampled on acceptance.
REQ-007 i_B  in  WIDTH  operand B, sampled on acceptance.
REQ-008 i_Mode  in  1  0 = A+B, 1 = A-B, sampled on acceptance.
REQ-009 o_busy  out  1  high while an operation is in progress.
REQ-010 o_done  out  1  one-cycle pulse, result valid.
REQ-011 o_Sum  out  WIDTH  result, held until next o_done.
REQ-012 o_Cout  out  1  carry out of MSB, held with o_Sum.
REQ-013 o_Ovf  out  1  signed overflow flag (present only per REQ-030).

Function
REQ-014 FSM states IDLE, RUN, DONE SHALL exist; o_busy=1 only in RUN; o_done=1 only in DONE.
REQ-015 IDLE or DONE with i_start=1 -> RUN at next edge: latch A, B XOR {WIDTH{i_Mode}}, carry=i_Mode, digit count=0.
REQ-016 IDLE or DONE with i_start=0 -> IDLE at next edge.
REQ-017 Each RUN edge SHALL add the lowest DIGIT bits of both latched operands plus carry, shift the digit sum into the result register from the MSB side, update carry, increment count.
REQ-018 RUN -> DONE at the edge processing digit N-1; o_Sum/o_Cout (and o_Ovf) SHALL update at that same edge.
REQ-019 Latency: o_done high exactly N rising edges after the edge that accepted i_start; throughput one operation per N+1 cycles.
REQ-020 i_start, i_A, i_B, i_Mode while in RUN SHALL be ignored; they SHALL NOT affect the operation in flight.
REQ-021 o_Sum/o_Cout SHALL hold their previous values during RUN and IDLE.
REQ-022 Result SHALL equal (A + B) mod 2^WIDTH for Mode 0 and (A - B) mod 2^WIDTH for Mode 1.
REQ-023 o_Cout SHALL be the raw carry of A + ~B + 1 for Mode 1 (1 = no borrow, A >= B unsigned).
REQ-024 N=1 (DIGIT=WIDTH) SHALL be supported: RUN lasts one cycle.

Reset
REQ-025 i_reset=1 at an edge SHALL force IDLE regardless of state, including mid-RUN (operation discarded, no o_done).
REQ-026 Reset values: o_busy=0, o_done=0, o_Sum=0, o_Cout=0, o_Ovf=0, carry=0, count=0.
REQ-027 i_reset SHALL take priority over i_start in the same cycle.

Configuration
REQ-028 Macro ADDSUB_SERIAL_OVF_EN SHALL select signed-overflow detection.
REQ-029 Without ADDSUB_SERIAL_OVF_EN: port o_Ovf and its logic SHALL be absent.
REQ-030 With ADDSUB_SERIAL_OVF_EN: o_Ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB of the final digit, updated with o_Sum.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-031 A=10,B=8,Mode=0 -> o_done 4 edges after start, o_Sum=18, o_Cout=0, o_Ovf=0.
REQ-032 A=10,B=9,Mode=1 -> o_Sum=1, o_Cout=1; A=0,B=1,Mode=1 -> o_Sum=0xFFFF, o_Cout=0.
REQ-033 A=0xFFFF,B=0x0001,Mode=0 -> o_Sum=0, o_Cout=1, o_Ovf=0; A=0x7FFF,B=1,Mode=0 -> o_Sum=0x8000, o_Ovf=1.
REQ-034 Second i_start with different operands during RUN -> ignored, first result unchanged; i_start in DONE cycle -> next op accepted, o_busy=1 next cycle.
REQ-035 i_reset pulsed at 2nd RUN cycle -> IDLE, no o_done, all outputs 0; fresh start afterwards completes correctly.
REQ-036 WIDTH=4, DIGIT=4: A=10,B=9,Mode=1 -> o_done 1 edge after start, o_Sum=1, o_Cout=1.
